latch_id_ex: RTL
================

# latch_id_ex

Pipeline register between instruction decode and execute in the 5-stage MIPS core. It captures the decoder's WB/MEM/EX control buses and jump/shift flags, plus the register-file operands, immediate, register indices, shamt and PC+4. It holds them for one cycle for the execute stage, the forwarding unit and the hazard unit. It supports bubble insertion (load-use hazard), flush (taken branch or jump) and a global freeze (debug step control).

## Interface
- NB_DATA, 32, operand/immediate/PC width
- NB_REG, 5, register index width
- NB_CTRL_EX, 6, EX bus width: [ALUSrc, AluOp[3:0], RegDst]
- NB_CTRL_M, 9, MEM bus width: [SB, SH, LB, LH, Unsigned, BNEQ, Branch, MemRead, MemWrite]
- NB_CTRL_WB, 2, WB bus width: [RegWrite, MemtoReg]

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-low reset
- i_enable  in  1  pipeline advance; 0 freezes every register (debug step mode)
- i_bubble  in  1  hazard unit: load-use stall, insert NOP into EX
- i_flush  in  1  branch/jump resolution: squash the instruction in decode
- i_ctrl_wb_bus / i_ctrl_mem_bus / i_ctrl_exc_bus  in  NB_CTRL_WB / NB_CTRL_M / NB_CTRL_EX  decoder control buses
- i_jump, i_jal, i_jr, i_jalr, i_shift  in  1 each  decoder flags
- i_pc_plus4, i_rs_data, i_rt_data, i_imm  in  NB_DATA each  PC+4, operand values, sign-extended immediate
- i_rs, i_rt, i_rd, i_shamt  in  NB_REG each  instruction fields
- o_ctrl_wb_bus / o_ctrl_mem_bus / o_ctrl_exc_bus  out  same widths  registered control
- o_jump, o_jal, o_jr, o_jalr, o_shift  out  1 each  registered flags
- o_pc_plus4, o_rs_data, o_rt_data, o_imm  out  NB_DATA  registered data
- o_rs, o_rt, o_rd, o_shamt  out  NB_REG  registered fields
- o_valid  out  1  1 = the EX slot holds a real instruction, 0 = a bubble
- o_bubble_cnt  out  NB_DATA  saturating count of bubbles and flushes inserted since reset

## Operation
- The update priority each rising edge is: reset > freeze > squash > load.
- Reset (i_rst=0): every output is cleared to 0, including o_valid and o_bubble_cnt. This applies regardless of i_enable.
- Freeze (i_enable=0): all registers hold, including the counter. i_bubble and i_flush are ignored.
- Squash (i_enable=1 and (i_bubble | i_flush)):
  - All three control buses and the five flags load 0. The resulting NOP writes no register, does not access memory and does not branch.
  - o_valid loads 0.
  - Data and field registers load their inputs normally. This keeps forwarding comparisons deterministic and is harmless because RegWrite=0.
  - o_bubble_cnt increments by 1 and saturates at all-ones. Simultaneous bubble and flush count once.
- Load (i_enable=1, no squash): all registers load their inputs, and o_valid loads 1.
- No combinational path from any input to any output. All outputs are flops.

## Timing
- Latency is 1 cycle: values present at edge N appear on the outputs after edge N and stay stable until edge N+1.
- i_bubble/i_flush asserted in cycle N cause a NOP in EX during cycle N+1. They have no effect in the same cycle.
- Freeze duration is unbounded. When i_enable returns to 1, the next edge resumes normally with no lost or duplicated instruction.
- Reset asserted mid-stream takes effect at the next edge and overrides a concurrent bubble, flush or freeze. The first edge with i_rst=1 performs a normal load.
- Counter wrap: at all-ones, further squashes leave the value unchanged.

## Test plan
- Reset: drive all inputs to all-ones, i_rst=0 for 2 edges -> every output 0, o_valid=0, o_bubble_cnt=0; release -> the next edge loads all-ones and o_valid=1.
- Normal load: LW decode (wb=2'b11, mem=9'b000000010, exc=6'b100000, rs=5, rt=8, imm=32'h4) -> the outputs match one cycle later, and each new instruction appears one edge after it is presented.
- Bubble: i_bubble=1 with ADD controls (wb=2'b10, exc=6'b000101) -> next cycle all control buses/flags are 0, o_valid=0, o_rs/o_rt are still loaded, o_bubble_cnt=1.
- Flush with JAL: i_flush=1, i_jal=1, i_bubble=1 in the same cycle -> o_jal=0, o_ctrl_wb_bus=0, o_bubble_cnt increments by exactly 1.
- Freeze: i_enable=0 for 5 cycles while the inputs change and i_flush=1 -> the outputs and the counter are unchanged; i_enable=1 -> the next edge loads the current inputs.
- Reset priority and saturation:
  - i_rst=0 with i_enable=0 -> all outputs are cleared.
  - Force 2^NB_DATA squashes (or a reduced-width parameter, NB_DATA=4, 17 squashes) -> the counter holds at all-ones.

Source files
------------

// File: rtl/latch_id_ex.sv
// latch_id_ex: ID/EX pipeline register of the 5-stage MIPS core.
//
// Captures the decoder's WB/MEM/EX control buses and jump/shift flags,
// together with the register-file operands, the immediate, the register
// indices, shamt and PC+4. The values are held for one cycle for the
// execute stage, the forwarding unit and the hazard unit.
//
// Ports:
//   i_clk, i_rst        clock; synchronous active-low reset
//   i_enable            pipeline advance (0 = freeze all state)
//   i_bubble, i_flush   squash requests (load-use stall / branch-jump)
//   i_ctrl_*_bus        decoder control buses (WB, MEM, EX)
//   i_jump..i_shift     decoder flags
//   i_pc_plus4, i_rs_data, i_rt_data, i_imm   data operands
//   i_rs, i_rt, i_rd, i_shamt                 instruction fields
//   o_*                 registered copies of the above
//   o_valid             1 = EX slot holds a real instruction
//   o_bubble_cnt        saturating count of squashes since reset
module latch_id_ex #(
    parameter int NB_DATA    = 32,
    parameter int NB_REG     = 5,
    parameter int NB_CTRL_EX = 6,
    parameter int NB_CTRL_M  = 9,
    parameter int NB_CTRL_WB = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_bubble,
    input  logic                  i_flush,
    input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
    input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
    input  logic [NB_CTRL_EX-1:0] i_ctrl_exc_bus,
    input  logic                  i_jump,
    input  logic                  i_jal,
    input  logic                  i_jr,
    input  logic                  i_jalr,
    input  logic                  i_shift,
    input  logic [NB_DATA-1:0]    i_pc_plus4,
    input  logic [NB_DATA-1:0]    i_rs_data,
    input  logic [NB_DATA-1:0]    i_rt_data,
    input  logic [NB_DATA-1:0]    i_imm,
    input  logic [NB_REG-1:0]     i_rs,
    input  logic [NB_REG-1:0]     i_rt,
    input  logic [NB_REG-1:0]     i_rd,
    input  logic [NB_REG-1:0]     i_shamt,
    output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
    output logic [NB_CTRL_M-1:0]  o_ctrl_mem_bus,
    output logic [NB_CTRL_EX-1:0] o_ctrl_exc_bus,
    output logic                  o_jump,
    output logic                  o_jal,
    output logic                  o_jr,
    output logic                  o_jalr,
    output logic                  o_shift,
    output logic [NB_DATA-1:0]    o_pc_plus4,
    output logic [NB_DATA-1:0]    o_rs_data,
    output logic [NB_DATA-1:0]    o_rt_data,
    output logic [NB_DATA-1:0]    o_imm,
    output logic [NB_REG-1:0]     o_rs,
    output logic [NB_REG-1:0]     o_rt,
    output logic [NB_REG-1:0]     o_rd,
    output logic [NB_REG-1:0]     o_shamt,
    output logic                  o_valid,
    output logic [NB_DATA-1:0]    o_bubble_cnt
);

    logic [NB_CTRL_WB-1:0] wb_q,    wb_d;
    logic [NB_CTRL_M-1:0]  mem_q,   mem_d;
    logic [NB_CTRL_EX-1:0] exc_q,   exc_d;
    logic                  jump_q,  jump_d;
    logic                  jal_q,   jal_d;
    logic                  jr_q,    jr_d;
    logic                  jalr_q,  jalr_d;
    logic                  shift_q, shift_d;
    logic [NB_DATA-1:0]    pc_q,    pc_d;
    logic [NB_DATA-1:0]    rsd_q,   rsd_d;
    logic [NB_DATA-1:0]    rtd_q,   rtd_d;
    logic [NB_DATA-1:0]    imm_q,   imm_d;
    logic [NB_REG-1:0]     rs_q,    rs_d;
    logic [NB_REG-1:0]     rt_q,    rt_d;
    logic [NB_REG-1:0]     rd_q,    rd_d;
    logic [NB_REG-1:0]     shamt_q, shamt_d;
    logic                  valid_q, valid_d;
    logic [NB_DATA-1:0]    cnt_q,   cnt_d;
    logic                  squash;

    // Bubble and flush collapse into one squash event, so a cycle that
    // raises both still counts only once.
    assign squash = i_bubble | i_flush;

    always_comb begin
        wb_d    = wb_q;
        mem_d   = mem_q;
        exc_d   = exc_q;
        jump_d  = jump_q;
        jal_d   = jal_q;
        jr_d    = jr_q;
        jalr_d  = jalr_q;
        shift_d = shift_q;
        pc_d    = pc_q;
        rsd_d   = rsd_q;
        rtd_d   = rtd_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        shamt_d = shamt_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (i_enable) begin
            // Data and fields load even on a squash: the NOP has
            // RegWrite=0, and forwarding compares stay deterministic.
            pc_d    = i_pc_plus4;
            rsd_d   = i_rs_data;
            rtd_d   = i_rt_data;
            imm_d   = i_imm;
            rs_d    = i_rs;
            rt_d    = i_rt;
            rd_d    = i_rd;
            shamt_d = i_shamt;
            if (squash) begin
                wb_d    = '0;
                mem_d   = '0;
                exc_d   = '0;
                jump_d  = 1'b0;
                jal_d   = 1'b0;
                jr_d    = 1'b0;
                jalr_d  = 1'b0;
                shift_d = 1'b0;
                valid_d = 1'b0;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + NB_DATA'(1);
                end
            end else begin
                wb_d    = i_ctrl_wb_bus;
                mem_d   = i_ctrl_mem_bus;
                exc_d   = i_ctrl_exc_bus;
                jump_d  = i_jump;
                jal_d   = i_jal;
                jr_d    = i_jr;
                jalr_d  = i_jalr;
                shift_d = i_shift;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wb_q    <= '0;
            mem_q   <= '0;
            exc_q   <= '0;
            jump_q  <= 1'b0;
            jal_q   <= 1'b0;
            jr_q    <= 1'b0;
            jalr_q  <= 1'b0;
            shift_q <= 1'b0;
            pc_q    <= '0;
            rsd_q   <= '0;
            rtd_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            shamt_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            wb_q    <= wb_d;
            mem_q   <= mem_d;
            exc_q   <= exc_d;
            jump_q  <= jump_d;
            jal_q   <= jal_d;
            jr_q    <= jr_d;
            jalr_q  <= jalr_d;
            shift_q <= shift_d;
            pc_q    <= pc_d;
            rsd_q   <= rsd_d;
            rtd_q   <= rtd_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            shamt_q <= shamt_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_ctrl_wb_bus  = wb_q;
    assign o_ctrl_mem_bus = mem_q;
    assign o_ctrl_exc_bus = exc_q;
    assign o_jump         = jump_q;
    assign o_jal          = jal_q;
    assign o_jr           = jr_q;
    assign o_jalr         = jalr_q;
    assign o_shift        = shift_q;
    assign o_pc_plus4     = pc_q;
    assign o_rs_data      = rsd_q;
    assign o_rt_data      = rtd_q;
    assign o_imm          = imm_q;
    assign o_rs           = rs_q;
    assign o_rt           = rt_q;
    assign o_rd           = rd_q;
    assign o_shamt        = shamt_q;
    assign o_valid        = valid_q;
    assign o_bubble_cnt   = cnt_q;

endmodule
